// File: rtl/cdl_wr_arb.sv
// Single-owner write port for the CDL topsig flop bank.
// Round-robin arbitration; each granted request applies one atomic read-modify-write.
module cdl_wr_arb #(
  parameter int unsigned      NREQ      = 4,
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       op,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         ack,
  output logic [WIDTH-1:0]        topsig,
  output logic                    busy
);

  localparam int unsigned     IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    COMMIT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_t;

  state_t           state, state_n;
  logic [IW-1:0]    ptr, ptr_n;
  logic [IW-1:0]    win, win_n;
  op_t              lop, lop_n;
  logic [WIDTH-1:0] ldata, ldata_n;
  logic [NREQ-1:0]  gnt_n, ack_n;
  logic [WIDTH-1:0] topsig_n;
  logic             busy_n;

  logic             found;
  logic [IW-1:0]    pick;
  logic [1:0]       pick_op;
  logic [WIDTH-1:0] pick_data;
  int unsigned      idx;

  // Cyclic scan for the first requester at or after ptr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[IW'(idx)]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // Operand mux for the candidate winner.
  always_comb begin
    pick_op   = '0;
    pick_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == pick) begin
        pick_op   = op[2*i +: 2];
        pick_data = wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    win_n    = win;
    lop_n    = lop;
    ldata_n  = ldata;
    gnt_n    = '0;
    ack_n    = '0;
    topsig_n = topsig;

    case (state)
      IDLE: begin
        if (found) begin
          win_n   = pick;
          lop_n   = op_t'(pick_op);
          ldata_n = pick_data;
          gnt_n   = ONE << pick;
          state_n = GRANT;
        end
      end
      GRANT: begin
        ack_n   = ONE << win;
        state_n = COMMIT;
      end
      COMMIT: begin
        case (lop)
          OP_WRITE:  topsig_n = ldata;
          OP_SET:    topsig_n = topsig | ldata;
          OP_CLEAR:  topsig_n = topsig & ~ldata;
          OP_TOGGLE: topsig_n = topsig ^ ldata;
          default:   topsig_n = topsig;
        endcase
        ptr_n   = (32'(win) == NREQ - 1) ? '0 : win + 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      win    <= '0;
      lop    <= OP_WRITE;
      ldata  <= '0;
      gnt    <= '0;
      ack    <= '0;
      topsig <= RESET_VAL;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      win    <= win_n;
      lop    <= lop_n;
      ldata  <= ldata_n;
      gnt    <= gnt_n;
      ack    <= ack_n;
      topsig <= topsig_n;
      busy   <= busy_n;
    end
  end

endmodule

// File: tb/tb_cdl_wr_arb.sv
// Directed bench for cdl_wr_arb: latency, round-robin order, RMW ops, reset abort.
module tb_cdl_wr_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [7:0]  topsig;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdl_wr_arb #(.NREQ(4), .WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op     (op),
    .wdata  (wdata),
    .gnt    (gnt),
    .ack    (ack),
    .topsig (topsig),
    .busy   (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] d);
    op[2*i +: 2]    = o;
    wdata[8*i +: 8] = d;
    req[i]          = 1'b1;
  endtask

  // One full transaction for winner w; optionally scrambles operands after grant.
  task automatic run_txn(input int w, input logic [7:0] exp, input bit drop, input bit scramble);
    logic [3:0] oh;
    oh = 4'b0001 << w;
    tick;
    check("gnt", 32'(gnt), 32'(oh));
    check("busy_grant", 32'(busy), 32'd1);
    if (scramble) begin
      op[2*w +: 2]    = ~op[2*w +: 2];
      wdata[8*w +: 8] = ~wdata[8*w +: 8];
    end
    tick;
    check("ack", 32'(ack), 32'(oh));
    check("gnt_off", 32'(gnt), 32'd0);
    if (drop) req[w] = 1'b0;
    tick;
    check("topsig", 32'(topsig), 32'(exp));
    check("ack_off", 32'(ack), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // gnt/ack exclusivity and one-hotness, every cycle outside reset.
  always @(negedge clk) begin
    if (reset === 1'b0)
      check("excl", {29'd0, (gnt != 4'd0) && (ack != 4'd0), $onehot0(gnt), $onehot0(ack)}, 32'd3);
  end

  initial begin
    logic [7:0] e;
    reset = 1'b1;
    req   = 4'hF;
    op    = 8'h00;
    wdata = 32'hFFFF_FFFF;

    // Reset held against requests.
    repeat (4) begin
      tick;
      check("rst_topsig", 32'(topsig), 32'h00);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    reset = 1'b0;
    req   = 4'h0;
    tick;
    check("idle_busy", 32'(busy), 32'd0);

    // Single write, operands changed after grant must be ignored.
    set_req(0, 2'b00, 8'hA5);
    run_txn(0, 8'hA5, 1'b1, 1'b1);

    // All four set a bit each: order 0,1,2,3.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 2'b01, 8'(1 << i));
    e = 8'h00;
    for (int i = 0; i < 4; i++) begin
      e = e | 8'(1 << i);
      run_txn(i, e, 1'b1, 1'b0);
    end

    // req[0] and req[2] held: alternate 0,2,0,2.
    set_req(0, 2'b00, 8'h11);
    set_req(2, 2'b00, 8'h22);
    run_txn(0, 8'h11, 1'b0, 1'b0);
    run_txn(2, 8'h22, 1'b0, 1'b0);
    run_txn(0, 8'h11, 1'b0, 1'b0);
    run_txn(2, 8'h22, 1'b0, 1'b0);
    req = 4'h0;

    // Read-modify-write ops.
    set_req(1, 2'b00, 8'hFF);
    run_txn(1, 8'hFF, 1'b1, 1'b0);
    set_req(1, 2'b10, 8'h0F);
    run_txn(1, 8'hF0, 1'b1, 1'b0);
    set_req(1, 2'b11, 8'hFF);
    run_txn(1, 8'h0F, 1'b1, 1'b0);
    set_req(0, 2'b01, 8'h30);
    run_txn(0, 8'h3F, 1'b1, 1'b0);

    // ptr is now 1; reset during GRANT for req[1] must abort and clear ptr.
    set_req(1, 2'b00, 8'h5A);
    tick;
    check("abort_gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    tick;
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_gnt_off", 32'(gnt), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_topsig", 32'(topsig), 32'h00);
    reset = 1'b0;
    set_req(0, 2'b00, 8'h77);
    run_txn(0, 8'h77, 1'b1, 1'b0);
    run_txn(1, 8'h5A, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
